truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
Sequencer that exhaustively exercises a 4-input combinational boolean block (a,b,c,d -> y), such as the NAND-only minterm realisations in this coursework set. On a start pulse it drives all 16 input vectors in order, waits a settle interval, samples y, and builds the observed truth table. It compares each sample against an expected 16-bit minterm mask and reports pass/fail, mismatch count and the first failing vector. It sits between the bench or top-level controls and the combinational block under check.

Parameters:
SETTLE_CYCLES, 1, cycles each vector is held before sampling; legal range 1..15.
EXPECTED, 16'hD117, expected truth table; bit i = y for vector i (minterms 0,1,2,4,8,12,14,15).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  begin sweep; sampled only in IDLE
dut_y  in  1  output of block under check
dut_a  out  1  input a to block (vec[3], MSB)
dut_b  out  1  input b (vec[2])
dut_c  out  1  input c (vec[1])
dut_d  out  1  input d (vec[0], LSB)
busy  out  1  high from the cycle after start acceptance until DONE
done  out  1  one-cycle pulse at sweep end
pass  out  1  1 iff the last completed sweep had zero mismatches
table  out  16  observed truth table; bit i = sampled y for vector i
mismatch_cnt  out  5  number of mismatching vectors, 0..16
first_fail  out  4  lowest failing vector index
fail_valid  out  1  first_fail holds a valid index

Behaviour:
- Reset (async, any state): state=IDLE, vec=0, settle counter=0, busy=0, done=0, pass=0, table=0, mismatch_cnt=0, first_fail=0, fail_valid=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: dut_{a,b,c,d} driven from vec (holds 0). When start=1 at an edge: vec<=0, table/mismatch_cnt/first_fail/fail_valid/pass cleared, settle counter<=0, go to DRIVE.
- DRIVE: vec held stable; counter increments every cycle; after SETTLE_CYCLES cycles in DRIVE, go to SAMPLE.
- SAMPLE: table[vec]<=dut_y. If dut_y!=EXPECTED[vec]: mismatch_cnt+1; if fail_valid=0, first_fail<=vec and fail_valid<=1. If vec==15, go to DONE. Otherwise vec<=vec+1, counter<=0, go to DRIVE. vec does not wrap inside a sweep.
- DONE: lasts exactly one cycle. done=1, busy=0, pass=(mismatch_cnt==0), vec<=0, go to IDLE.
- busy=1 in DRIVE and SAMPLE only.
- Timing: with start sampled at edge T, done is high in the cycle following edge T+16*(SETTLE_CYCLES+1)+1 (T+33 for SETTLE_CYCLES=1).
- start is ignored in DRIVE, SAMPLE and DONE; it is not queued. If start is held high, a new sweep is accepted on the first IDLE edge after DONE.
- Results (table, mismatch_cnt, first_fail, fail_valid, pass) hold after DONE until the next start is accepted or reset.
- dut_y is treated as a purely combinational function of the dut_* outputs. The sweeper adds no synchronisers.

Optional Feature:
TT_STOP_ON_FAIL_EN:
- Defined: the first mismatch in SAMPLE goes directly to DONE. Remaining table bits stay 0, mismatch_cnt=1, first_fail=the failing vector, pass=0.
- Undefined: all 16 vectors are always swept. No port differences between the two builds.

Test Plan:
- Golden model (dut_y=EXPECTED[vec]), SETTLE_CYCLES=1, single start pulse -> busy high 32 cycles; done at edge T+33; table=16'hD117; mismatch_cnt=0; pass=1; fail_valid=0.
- dut_y stuck at 0 -> table=16'h0000; mismatch_cnt=8; first_fail=0; fail_valid=1; pass=0.
- Golden model with vector 5 forced to 1 -> table=16'hD137; mismatch_cnt=1; first_fail=5; pass=0.
- start pulsed again 10 cycles into a sweep -> ignored; done timing and results unchanged. start held high continuously -> second sweep accepted the cycle after DONE; results cleared, then reproduced.
- rst asserted while vec=7 is in DRIVE -> immediately busy=0, done=0, vec=0, table=0, mismatch_cnt=0. The next start produces a full, correct 16-vector sweep.
- TT_STOP_ON_FAIL_EN defined, fault at vector 5, SETTLE_CYCLES=1 -> done at edge T+13; mismatch_cnt=1; first_fail=5; table=16'h0017.

Source files
------------

// File: rtl/truth_table_sweeper_if.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_if
// Bundles the control, stimulus and result signals of truth_table_sweeper.
//   i_start          begin a sweep (controller -> sweeper)
//   i_dut_y          output of the combinational block under check
//   o_dut_a..o_dut_d stimulus vector bits a (MSB) .. d (LSB)
//   o_busy           sweep in progress
//   o_done           one-cycle pulse at the end of a sweep
//   o_pass           last completed sweep had zero mismatches
//   o_table          observed truth table, bit i = y for vector i
//   o_mismatch_cnt   number of mismatching vectors (0..16)
//   o_first_fail     lowest failing vector index
//   o_fail_valid     o_first_fail holds a valid index
// master = controller / block-under-check side, slave = sweeper side.
// -----------------------------------------------------------------------------
interface truth_table_sweeper_if;
   logic        i_start;
   logic        i_dut_y;
   logic        o_dut_a;
   logic        o_dut_b;
   logic        o_dut_c;
   logic        o_dut_d;
   logic        o_busy;
   logic        o_done;
   logic        o_pass;
   logic [15:0] o_table;
   logic [4:0]  o_mismatch_cnt;
   logic [3:0]  o_first_fail;
   logic        o_fail_valid;

   modport master (
      output i_start, i_dut_y,
      input  o_dut_a, o_dut_b, o_dut_c, o_dut_d,
      input  o_busy, o_done, o_pass, o_table, o_mismatch_cnt,
      input  o_first_fail, o_fail_valid
   );

   modport slave (
      input  i_start, i_dut_y,
      output o_dut_a, o_dut_b, o_dut_c, o_dut_d,
      output o_busy, o_done, o_pass, o_table, o_mismatch_cnt,
      output o_first_fail, o_fail_valid
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Drives all 16 input vectors of a 4-input combinational block, holds each for
// SETTLE_CYCLES cycles, samples y and compares against the EXPECTED mask.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   bus_if truth_table_sweeper_if.slave (start, dut_y, dut_a..d, status/results)
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before sampling (1..15)
//   EXPECTED       expected truth table, bit i = y for vector i
// Build option:
//   TT_STOP_ON_FAIL_EN  when defined, the first mismatch ends the sweep.
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter logic [15:0] EXPECTED      = 16'hD117
) (
   input logic                   clk,
   input logic                   rst,
   truth_table_sweeper_if.slave  bus_if
);

   localparam int unsigned VEC_W = 4;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned MCN_W = 5;
   localparam int unsigned TBL_W = 16;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRIVE  = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t             r_state, w_state;
   logic [VEC_W-1:0]   r_vec, w_vec;
   logic [CNT_W-1:0]   r_cnt, w_cnt;
   logic [TBL_W-1:0]   r_table, w_table;
   logic [MCN_W-1:0]   r_mcnt, w_mcnt;
   logic [VEC_W-1:0]   r_ff, w_ff;
   logic               r_fv, w_fv;
   logic               r_pass, w_pass;
   logic               r_busy, w_busy;
   logic               r_done, w_done;
   logic               w_mis;

   // State and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_vec   <= '0;
         r_cnt   <= '0;
         r_table <= '0;
         r_mcnt  <= '0;
         r_ff    <= '0;
         r_fv    <= 1'b0;
         r_pass  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_vec   <= w_vec;
         r_cnt   <= w_cnt;
         r_table <= w_table;
         r_mcnt  <= w_mcnt;
         r_ff    <= w_ff;
         r_fv    <= w_fv;
         r_pass  <= w_pass;
         r_busy  <= w_busy;
         r_done  <= w_done;
      end
   end

   // Next-state and next-result logic
   always_comb begin
      w_state = r_state;
      w_vec   = r_vec;
      w_cnt   = r_cnt;
      w_table = r_table;
      w_mcnt  = r_mcnt;
      w_ff    = r_ff;
      w_fv    = r_fv;
      w_pass  = r_pass;
      w_done  = 1'b0;
      w_mis   = (bus_if.i_dut_y != EXPECTED[r_vec]);

      case (r_state)
         S_IDLE: begin
            if (bus_if.i_start) begin
               w_state = S_DRIVE;
               w_vec   = '0;
               w_cnt   = '0;
               w_table = '0;
               w_mcnt  = '0;
               w_ff    = '0;
               w_fv    = 1'b0;
               w_pass  = 1'b0;
            end
         end

         S_DRIVE: begin
            w_cnt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
               w_state = S_SAMPLE;
            end
         end

         S_SAMPLE: begin
            if (w_mis) begin
               w_mcnt = r_mcnt + MCN_W'(1);
               if (!r_fv) begin
                  w_ff = r_vec;
                  w_fv = 1'b1;
               end
            end
`ifdef TT_STOP_ON_FAIL_EN
            // Failing sample is not recorded; table keeps only passing vectors.
            if (w_mis) begin
               w_state = S_DONE;
            end else begin
               w_table[r_vec] = bus_if.i_dut_y;
               if (r_vec == VEC_W'(15)) begin
                  w_state = S_DONE;
               end else begin
                  w_vec   = r_vec + VEC_W'(1);
                  w_cnt   = '0;
                  w_state = S_DRIVE;
               end
            end
`else
            w_table[r_vec] = bus_if.i_dut_y;
            if (r_vec == VEC_W'(15)) begin
               w_state = S_DONE;
            end else begin
               w_vec   = r_vec + VEC_W'(1);
               w_cnt   = '0;
               w_state = S_DRIVE;
            end
`endif
         end

         S_DONE: begin
            w_done  = 1'b1;
            w_pass  = (r_mcnt == '0);
            w_vec   = '0;
            w_state = S_IDLE;
         end

         default: begin
            w_state = S_IDLE;
         end
      endcase

      // Registered busy tracks the state being entered
      w_busy = (w_state == S_DRIVE) || (w_state == S_SAMPLE);
   end

   assign bus_if.o_dut_a        = r_vec[3];
   assign bus_if.o_dut_b        = r_vec[2];
   assign bus_if.o_dut_c        = r_vec[1];
   assign bus_if.o_dut_d        = r_vec[0];
   assign bus_if.o_busy         = r_busy;
   assign bus_if.o_done         = r_done;
   assign bus_if.o_pass         = r_pass;
   assign bus_if.o_table        = r_table;
   assign bus_if.o_mismatch_cnt = r_mcnt;
   assign bus_if.o_first_fail   = r_ff;
   assign bus_if.o_fail_valid   = r_fv;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
// Directed bench for truth_table_sweeper (SETTLE_CYCLES=1, EXPECTED=16'hD117).
// A small model of the block under check produces dut_y from the driven vector
// with a selectable fault: none, stuck-at-0, or vector 5 forced to 1.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;
   int   fault_mode;
   logic [15:0] golden;
   logic [3:0]  w_vec;
   logic        w_y;

   truth_table_sweeper_if bus();

   truth_table_sweeper #(
      .SETTLE_CYCLES (1),
      .EXPECTED      (16'hD117)
   ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign w_vec = {bus.o_dut_a, bus.o_dut_b, bus.o_dut_c, bus.o_dut_d};

   // Block-under-check model
   always_comb begin
      w_y = golden[w_vec];
      case (fault_mode)
         1:       w_y = 1'b0;
         2:       w_y = (w_vec == 4'd5) ? 1'b1 : golden[w_vec];
         default: w_y = golden[w_vec];
      endcase
   end
   assign bus.i_dut_y = w_y;

   // Pulse start, return edges from acceptance to done and busy-cycle count
   task automatic do_sweep(input bit mid_pulse, output int lat, output int busy_n);
      lat    = 0;
      busy_n = 0;
      @(negedge clk);
      bus.i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_start = 1'b0;
      if (bus.o_busy) busy_n++;
      while (!bus.o_done && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         bus.i_start = (mid_pulse && lat == 10);
         if (bus.o_busy) busy_n++;
      end
      bus.i_start = 1'b0;
   endtask

   task automatic test_reset();
      n_total++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.o_busy); else n_pass++;
      n_total++; if (bus.o_done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.o_done); else n_pass++;
      n_total++; if (bus.o_table !== 16'h0000) $display("FAIL reset_table: got %h want 0000", bus.o_table); else n_pass++;
      n_total++; if (w_vec !== 4'd0) $display("FAIL reset_vec: got %0d want 0", w_vec); else n_pass++;
      n_total++; if ({bus.o_pass, bus.o_fail_valid, bus.o_mismatch_cnt, bus.o_first_fail} !== 11'd0)
         $display("FAIL reset_results: got pass=%b fv=%b mc=%0d ff=%0d want all 0",
                  bus.o_pass, bus.o_fail_valid, bus.o_mismatch_cnt, bus.o_first_fail);
      else n_pass++;
   endtask

   task automatic test_golden(input string tag, input bit mid_pulse);
      int lat, busy_n;
      fault_mode = 0;
      do_sweep(mid_pulse, lat, busy_n);
      n_total++; if (lat !== 33) $display("FAIL %s_latency: got %0d want 33", tag, lat); else n_pass++;
      n_total++; if (busy_n !== 32) $display("FAIL %s_busy_cycles: got %0d want 32", tag, busy_n); else n_pass++;
      n_total++; if (bus.o_table !== 16'hD117) $display("FAIL %s_table: got %h want d117", tag, bus.o_table); else n_pass++;
      n_total++; if (bus.o_mismatch_cnt !== 5'd0) $display("FAIL %s_mcnt: got %0d want 0", tag, bus.o_mismatch_cnt); else n_pass++;
      n_total++; if (bus.o_pass !== 1'b1) $display("FAIL %s_pass: got %b want 1", tag, bus.o_pass); else n_pass++;
      n_total++; if (bus.o_fail_valid !== 1'b0) $display("FAIL %s_fv: got %b want 0", tag, bus.o_fail_valid); else n_pass++;
      @(negedge clk);
      n_total++; if (bus.o_done !== 1'b0) $display("FAIL %s_done_pulse: got %b want 0", tag, bus.o_done); else n_pass++;
      n_total++; if (bus.o_table !== 16'hD117) $display("FAIL %s_table_hold: got %h want d117", tag, bus.o_table); else n_pass++;
   endtask

   task automatic test_stuck0();
      int lat, busy_n;
      int e_lat;
      int e_mc;
      fault_mode = 1;
`ifdef TT_STOP_ON_FAIL_EN
      e_lat = 3;  e_mc = 1;
`else
      e_lat = 33; e_mc = 8;
`endif
      do_sweep(1'b0, lat, busy_n);
      n_total++; if (lat !== e_lat) $display("FAIL stuck0_latency: got %0d want %0d", lat, e_lat); else n_pass++;
      n_total++; if (bus.o_table !== 16'h0000) $display("FAIL stuck0_table: got %h want 0000", bus.o_table); else n_pass++;
      n_total++; if (bus.o_mismatch_cnt !== 5'(e_mc)) $display("FAIL stuck0_mcnt: got %0d want %0d", bus.o_mismatch_cnt, e_mc); else n_pass++;
      n_total++; if (bus.o_first_fail !== 4'd0) $display("FAIL stuck0_ff: got %0d want 0", bus.o_first_fail); else n_pass++;
      n_total++; if (bus.o_fail_valid !== 1'b1) $display("FAIL stuck0_fv: got %b want 1", bus.o_fail_valid); else n_pass++;
      n_total++; if (bus.o_pass !== 1'b0) $display("FAIL stuck0_pass: got %b want 0", bus.o_pass); else n_pass++;
   endtask

   task automatic test_fault5();
      int lat, busy_n;
      int e_lat;
      logic [15:0] e_tbl;
      fault_mode = 2;
`ifdef TT_STOP_ON_FAIL_EN
      e_lat = 13; e_tbl = 16'h0017;
`else
      e_lat = 33; e_tbl = 16'hD137;
`endif
      do_sweep(1'b0, lat, busy_n);
      n_total++; if (lat !== e_lat) $display("FAIL fault5_latency: got %0d want %0d", lat, e_lat); else n_pass++;
      n_total++; if (bus.o_table !== e_tbl) $display("FAIL fault5_table: got %h want %h", bus.o_table, e_tbl); else n_pass++;
      n_total++; if (bus.o_mismatch_cnt !== 5'd1) $display("FAIL fault5_mcnt: got %0d want 1", bus.o_mismatch_cnt); else n_pass++;
      n_total++; if (bus.o_first_fail !== 4'd5) $display("FAIL fault5_ff: got %0d want 5", bus.o_first_fail); else n_pass++;
      n_total++; if (bus.o_fail_valid !== 1'b1) $display("FAIL fault5_fv: got %b want 1", bus.o_fail_valid); else n_pass++;
      n_total++; if (bus.o_pass !== 1'b0) $display("FAIL fault5_pass: got %b want 0", bus.o_pass); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int lat, busy_n;
      fault_mode = 0;
      do_sweep(1'b0, lat, busy_n);
      // Hold start: first IDLE edge after done accepts the next sweep
      bus.i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_total++; if (bus.o_busy !== 1'b1) $display("FAIL b2b_accept_busy: got %b want 1", bus.o_busy); else n_pass++;
      n_total++; if (bus.o_table !== 16'h0000) $display("FAIL b2b_cleared_table: got %h want 0000", bus.o_table); else n_pass++;
      n_total++; if (bus.o_pass !== 1'b0) $display("FAIL b2b_cleared_pass: got %b want 0", bus.o_pass); else n_pass++;
      lat = 0;
      while (!bus.o_done && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      bus.i_start = 1'b0;
      n_total++; if (lat !== 33) $display("FAIL b2b_latency: got %0d want 33", lat); else n_pass++;
      n_total++; if (bus.o_table !== 16'hD117) $display("FAIL b2b_table: got %h want d117", bus.o_table); else n_pass++;
      n_total++; if (bus.o_pass !== 1'b1) $display("FAIL b2b_pass: got %b want 1", bus.o_pass); else n_pass++;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int guard;
      fault_mode = 0;
      @(negedge clk);
      bus.i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_start = 1'b0;
      guard = 0;
      while (w_vec != 4'd7 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      n_total++; if (w_vec !== 4'd7 || bus.o_busy !== 1'b1)
         $display("FAIL rstmid_reach_vec7: got vec=%0d busy=%b want 7/1", w_vec, bus.o_busy);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_total++; if (bus.o_busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.o_busy); else n_pass++;
      n_total++; if (w_vec !== 4'd0) $display("FAIL rstmid_vec: got %0d want 0", w_vec); else n_pass++;
      n_total++; if (bus.o_table !== 16'h0000) $display("FAIL rstmid_table: got %h want 0000", bus.o_table); else n_pass++;
      n_total++; if (bus.o_mismatch_cnt !== 5'd0 || bus.o_done !== 1'b0)
         $display("FAIL rstmid_mcnt_done: got mc=%0d done=%b want 0/0", bus.o_mismatch_cnt, bus.o_done);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      test_golden("after_rst", 1'b0);
   endtask

   initial begin
      n_pass      = 0;
      n_total     = 0;
      fault_mode  = 0;
      golden      = 16'hD117;
      rst         = 1'b1;
      bus.i_start = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_golden("golden", 1'b0);
      test_stuck0();
      test_fault5();
      test_golden("mid_start", 1'b1);
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
